// File: rtl/ram_cmd_arbiter.sv
// Two-port round-robin arbiter that turns write/read transactions into
// registered two-word RAM command sequences and routes read data back.
module ram_cmd_arbiter #(
    parameter int ADDR_SIZE  = 8,
    parameter int RD_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic                 req0_wr,
    input  logic [ADDR_SIZE-1:0] req0_addr,
    input  logic [ADDR_SIZE-1:0] req0_wdata,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic                 req1_wr,
    input  logic [ADDR_SIZE-1:0] req1_addr,
    input  logic [ADDR_SIZE-1:0] req1_wdata,

    output logic                 rsp0_valid,
    output logic [ADDR_SIZE-1:0] rsp0_rdata,
    output logic                 rsp0_err,

    output logic                 rsp1_valid,
    output logic [ADDR_SIZE-1:0] rsp1_rdata,
    output logic                 rsp1_err,

    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic [ADDR_SIZE-1:0] ram_dout,
    input  logic                 ram_tx_valid
);

    localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

    localparam logic [1:0] CMD_WADDR = 2'b00;
    localparam logic [1:0] CMD_WDATA = 2'b01;
    localparam logic [1:0] CMD_RADDR = 2'b10;
    localparam logic [1:0] CMD_RREAD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        W_ADDR,
        W_DATA,
        R_ADDR,
        R_CMD,
        R_WAIT
    } state_t;

    state_t               state;
    state_t               state_next;

    logic                 last_port;
    logic                 last_next;
    logic                 cur_port;
    logic [ADDR_SIZE-1:0] cur_wdata;
    logic [CNT_W-1:0]     wait_cnt;
    logic [CNT_W-1:0]     cnt_next;

    logic [ADDR_SIZE+1:0] din_next;
    logic                 rx_next;
    logic                 capture;
    logic                 rsp_fire;
    logic                 rsp_err_next;
    logic [ADDR_SIZE-1:0] rsp_data_next;

    logic                 grant_port;
    logic                 handshake;
    logic                 sel_wr;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [ADDR_SIZE-1:0] sel_wdata;

    // On a tie the port that was not served last wins; otherwise the sole
    // valid port wins.
    always_comb begin
        grant_port = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_port = ~last_port;
        end else if (req1_valid) begin
            grant_port = 1'b1;
        end
        handshake  = (state == IDLE) && (req0_valid || req1_valid);
        req0_ready = (state == IDLE) && req0_valid && !grant_port;
        req1_ready = (state == IDLE) && req1_valid && grant_port;
        sel_wr     = grant_port ? req1_wr    : req0_wr;
        sel_addr   = grant_port ? req1_addr  : req0_addr;
        sel_wdata  = grant_port ? req1_wdata : req0_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ram_din holds its last word once rx_valid drops, so din_next defaults
    // to the current value rather than zero.
    always_comb begin
        state_next    = state;
        din_next      = ram_din;
        rx_next       = 1'b0;
        capture       = 1'b0;
        last_next     = last_port;
        cnt_next      = '0;
        rsp_fire      = 1'b0;
        rsp_err_next  = 1'b0;
        rsp_data_next = '0;

        case (state)
            IDLE: begin
                if (handshake) begin
                    capture   = 1'b1;
                    last_next = grant_port;
                    rx_next   = 1'b1;
                    if (sel_wr) begin
                        din_next   = {CMD_WADDR, sel_addr};
                        state_next = W_ADDR;
                    end else begin
                        din_next   = {CMD_RADDR, sel_addr};
                        state_next = R_ADDR;
                    end
                end
            end
            W_ADDR: begin
                rx_next    = 1'b1;
                din_next   = {CMD_WDATA, cur_wdata};
                state_next = W_DATA;
            end
            W_DATA: begin
                state_next = IDLE;
            end
            R_ADDR: begin
                rx_next    = 1'b1;
                din_next   = {CMD_RREAD, {ADDR_SIZE{1'b0}}};
                state_next = R_CMD;
            end
            R_CMD: begin
                state_next = R_WAIT;
            end
            R_WAIT: begin
                if (ram_tx_valid) begin
                    rsp_fire      = 1'b1;
                    rsp_data_next = ram_dout;
                    state_next    = IDLE;
                end else if (wait_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
                    rsp_fire     = 1'b1;
                    rsp_err_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    cnt_next = wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset points last_port at 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
            last_port    <= 1'b1;
            cur_port     <= 1'b0;
            cur_wdata    <= '0;
            wait_cnt     <= '0;
        end else begin
            ram_din      <= din_next;
            ram_rx_valid <= rx_next;
            last_port    <= last_next;
            wait_cnt     <= cnt_next;
            if (capture) begin
                cur_port  <= grant_port;
                cur_wdata <= sel_wdata;
            end
        end
    end

    // Response data and error stay put between responses on each port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            rsp0_valid <= rsp_fire && !cur_port;
            rsp1_valid <= rsp_fire && cur_port;
            if (rsp_fire && !cur_port) begin
                rsp0_rdata <= rsp_data_next;
                rsp0_err   <= rsp_err_next;
            end
            if (rsp_fire && cur_port) begin
                rsp1_rdata <= rsp_data_next;
                rsp1_err   <= rsp_err_next;
            end
        end
    end

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Directed self-checking bench for ram_cmd_arbiter with a small behavioural
// RAM that decodes the command words and answers reads one cycle later.
module tb_ram_cmd_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_wr;
    logic [7:0] req0_addr, req0_wdata;
    logic       req1_valid, req1_ready, req1_wr;
    logic [7:0] req1_addr, req1_wdata;
    logic       rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [7:0] rsp0_rdata, rsp1_rdata;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout;
    logic       ram_tx_valid;

    logic [7:0] mem [256];
    logic [7:0] wr_ptr, rd_ptr;
    logic       model_tx;
    logic [7:0] model_dout;
    logic       ram_mute;
    logic       stray_tx;

    int compared;
    int mismatched;
    int rsp0_pulses;
    int snap;
    int waited;

    ram_cmd_arbiter #(.ADDR_SIZE(8), .RD_TIMEOUT(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_wr      (req0_wr),
        .req0_addr    (req0_addr),
        .req0_wdata   (req0_wdata),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_wr      (req1_wr),
        .req1_addr    (req1_addr),
        .req1_wdata   (req1_wdata),
        .rsp0_valid   (rsp0_valid),
        .rsp0_rdata   (rsp0_rdata),
        .rsp0_err     (rsp0_err),
        .rsp1_valid   (rsp1_valid),
        .rsp1_rdata   (rsp1_rdata),
        .rsp1_err     (rsp1_err),
        .ram_din      (ram_din),
        .ram_rx_valid (ram_rx_valid),
        .ram_dout     (ram_dout),
        .ram_tx_valid (ram_tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: read data returns the cycle after the read command.
    always @(posedge clk) begin
        model_tx <= 1'b0;
        if (ram_rx_valid) begin
            case (ram_din[9:8])
                2'b00: wr_ptr <= ram_din[7:0];
                2'b01: mem[wr_ptr] <= ram_din[7:0];
                2'b10: rd_ptr <= ram_din[7:0];
                default: begin
                    if (!ram_mute) begin
                        model_tx   <= 1'b1;
                        model_dout <= mem[rd_ptr];
                    end
                end
            endcase
        end
    end

    assign ram_dout     = model_dout;
    assign ram_tx_valid = model_tx | stray_tx;

    always @(posedge clk) begin
        if (rsp0_valid) rsp0_pulses <= rsp0_pulses + 1;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v0, input logic w0, input logic [7:0] a0,
                                 input logic [7:0] d0, input logic v1, input logic w1,
                                 input logic [7:0] a1, input logic [7:0] d1);
        req0_valid = v0; req0_wr = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_wr = w1; req1_addr = a1; req1_wdata = d1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitReady();
        waited = 0;
        while (!(req0_ready || req1_ready) && waited < 10) begin
            tick();
            #1;
            waited++;
        end
        checkOutput("grant_timeout", (waited < 10), 1);
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        rsp0_pulses = 0;
        ram_mute    = 1'b0;
        stray_tx    = 1'b0;
        rst_n       = 1'b0;
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        tick();
        tick();

        // Reset state
        checkOutput("rst_rx_valid", ram_rx_valid, 0);
        checkOutput("rst_din", ram_din, 0);
        checkOutput("rst_rsp0_valid", rsp0_valid, 0);
        checkOutput("rst_rsp1_valid", rsp1_valid, 0);
        checkOutput("rst_rsp0_rdata", rsp0_rdata, 0);
        checkOutput("rst_rsp1_err", rsp1_err, 0);

        // Write 0x3C <= 0xA5 from port 0, then read it back
        rst_n = 1'b1;
        applyStimulus(1, 1, 8'h3C, 8'hA5, 0, 0, 8'h00, 8'h00);
        #1;
        checkOutput("wr_ready0", req0_ready, 1);
        checkOutput("wr_ready1", req1_ready, 0);
        tick();
        applyStimulus(0, 0, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00);
        #1;
        checkOutput("wr_cmd_addr", ram_din, 10'h03C);
        checkOutput("wr_rx0", ram_rx_valid, 1);
        checkOutput("wr_busy_ready", req0_ready, 0);
        tick();
        checkOutput("wr_cmd_data", ram_din, 10'h1A5);
        checkOutput("wr_rx1", ram_rx_valid, 1);
        tick();
        checkOutput("wr_rx_end", ram_rx_valid, 0);
        checkOutput("wr_din_hold", ram_din, 10'h1A5);
        checkOutput("wr_no_rsp", rsp0_valid, 0);
        applyStimulus(1, 0, 8'h3C, 8'h00, 0, 0, 8'h00, 8'h00);
        #1;
        checkOutput("rd_ready0", req0_ready, 1);
        tick();
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        checkOutput("rd_cmd_addr", ram_din, 10'h23C);
        tick();
        checkOutput("rd_cmd_read", ram_din, 10'h300);
        checkOutput("rd_rx1", ram_rx_valid, 1);
        tick();
        checkOutput("rd_rx_end", ram_rx_valid, 0);
        checkOutput("rd_rsp_early", rsp0_valid, 0);
        tick();
        checkOutput("rd_rsp0_valid", rsp0_valid, 1);
        checkOutput("rd_rsp0_rdata", rsp0_rdata, 8'hA5);
        checkOutput("rd_rsp0_err", rsp0_err, 0);
        checkOutput("rd_rsp1_quiet", rsp1_valid, 0);

        // Both ports contend every IDLE cycle; port 0 was served last
        applyStimulus(1, 0, 8'h3C, 8'h00, 1, 0, 8'h3C, 8'h00);
        for (int k = 0; k < 4; k++) begin
            #1;
            waitReady();
            checkOutput("rr_grant0", req0_ready, (k % 2 == 1) ? 1 : 0);
            checkOutput("rr_exclusive", req0_ready & req1_ready, 0);
            tick();
        end
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        checkOutput("rd_pulse_len", rsp0_valid, 0);
        tick();
        tick();
        tick();
        checkOutput("rr_last_rsp0", rsp0_valid, 1);
        checkOutput("rr_rsp0_rdata", rsp0_rdata, 8'hA5);
        checkOutput("rr_rsp1_rdata", rsp1_rdata, 8'hA5);
        tick();
        checkOutput("rr_pulse_end", rsp0_valid, 0);

        // Only port 1 active for three reads
        snap = rsp0_pulses;
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'h3C, 8'h00);
        for (int k = 0; k < 3; k++) begin
            #1;
            waitReady();
            checkOutput("solo_ready1", req1_ready, 1);
            checkOutput("solo_ready0", req0_ready, 0);
            tick();
        end
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        tick();
        tick();
        tick();
        checkOutput("solo_rsp1_valid", rsp1_valid, 1);
        checkOutput("solo_rsp0_valid", rsp0_valid, 0);
        tick();
        checkOutput("solo_rsp0_pulses", rsp0_pulses - snap, 0);

        // RAM stays silent: read must time out after 8 wait cycles
        ram_mute = 1'b1;
        applyStimulus(1, 0, 8'h3C, 8'h00, 0, 0, 8'h00, 8'h00);
        #1;
        checkOutput("to_ready0", req0_ready, 1);
        tick();
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        for (int k = 0; k < 9; k++) tick();
        checkOutput("to_not_yet", rsp0_valid, 0);
        tick();
        checkOutput("to_rsp0_valid", rsp0_valid, 1);
        checkOutput("to_rsp0_rdata", rsp0_rdata, 8'h00);
        checkOutput("to_rsp0_err", rsp0_err, 1);
        stray_tx = 1'b1;
        tick();
        stray_tx = 1'b0;
        checkOutput("to_pulse_end", rsp0_valid, 0);
        checkOutput("to_err_hold", rsp0_err, 1);
        tick();
        checkOutput("stray_rsp0", rsp0_valid, 0);
        checkOutput("stray_rsp1", rsp1_valid, 0);
        ram_mute = 1'b0;

        // Reset in the middle of a write's data phase
        applyStimulus(1, 1, 8'h55, 8'h66, 0, 0, 8'h00, 8'h00);
        #1;
        checkOutput("mr_ready0", req0_ready, 1);
        tick();
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        tick();
        checkOutput("mr_wdata", ram_din, 10'h166);
        rst_n = 1'b0;
        #1;
        checkOutput("mr_rx_drop", ram_rx_valid, 0);
        checkOutput("mr_din_clear", ram_din, 0);
        checkOutput("mr_err_clear", rsp0_err, 0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1, 0, 8'h3C, 8'h00, 1, 0, 8'h3C, 8'h00);
        #1;
        checkOutput("mr_tie_ready0", req0_ready, 1);
        checkOutput("mr_tie_ready1", req1_ready, 0);
        tick();
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        checkOutput("mr_no_rsp0", rsp0_valid, 0);
        checkOutput("mr_no_rsp1", rsp1_valid, 0);
        tick();
        tick();
        tick();
        checkOutput("mr_rsp0_valid", rsp0_valid, 1);
        checkOutput("mr_rsp0_rdata", rsp0_rdata, 8'hA5);

        // Back-to-back writes from port 0, one handshake every three cycles
        applyStimulus(1, 1, 8'h40, 8'hC0, 0, 0, 8'h00, 8'h00);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("b2b_ready", req0_ready, 1);
            tick();
            if (k < 2) applyStimulus(1, 1, 8'h41 + 8'(k), 8'hC1 + 8'(k), 0, 0, 8'h00, 8'h00);
            else applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
            checkOutput("b2b_addr", ram_din, {2'b00, 8'h40 + 8'(k)});
            checkOutput("b2b_rx_a", ram_rx_valid, 1);
            tick();
            checkOutput("b2b_data", ram_din, {2'b01, 8'hC0 + 8'(k)});
            checkOutput("b2b_rx_d", ram_rx_valid, 1);
            tick();
            checkOutput("b2b_rx_idle", ram_rx_valid, 0);
        end
        applyStimulus(1, 0, 8'h41, 8'h00, 0, 0, 8'h00, 8'h00);
        #1;
        checkOutput("b2b_rd_ready", req0_ready, 1);
        tick();
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        tick();
        tick();
        tick();
        checkOutput("b2b_rd_valid", rsp0_valid, 1);
        checkOutput("b2b_rd_rdata", rsp0_rdata, 8'hC1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
